// File: rtl/sb_checker.sv
// ----------------------------------------------------------------------------
// sb_checker -- scoreboard comparator.
//
// Compares each DUT output word (act_*) against the head of an expected-data
// FIFO (exp_*), popping the FIFO on every compared beat. It counts matches and
// errors, captures the first mismatching pair, and flags a stall timeout
// when expected data sits pending with no DUT output for TIMEOUT cycles.
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   start                  arm the checker (from IDLE or DONE)
//   finish                 stimulus done; drain remaining expected words
//   act_valid, act_data    DUT output beat
//   exp_empty, exp_data    expected FIFO status and head word
//   exp_pop                pop request to the expected FIFO (combinational)
//   match_cnt, err_cnt     saturating match / error counters
//   first_exp, first_act   first mismatching expected / actual pair
//   busy, done             RUN or DRAIN / DONE state indicators
//   timeout                stall timeout occurred during this run
//   pass                   run finished with no errors and no timeout
// ----------------------------------------------------------------------------
module sb_checker #(
    parameter int              WIDTH   = 32,
    parameter logic [WIDTH-1:0] MASK   = {WIDTH{1'b1}},
    parameter int              TIMEOUT = 1024,
    parameter int              CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             finish,
    input  logic             act_valid,
    input  logic [WIDTH-1:0] act_data,
    input  logic             exp_empty,
    input  logic [WIDTH-1:0] exp_data,
    output logic             exp_pop,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [WIDTH-1:0] first_exp,
    output logic [WIDTH-1:0] first_act,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic             pass
);

    localparam int STALL_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state, state_nxt;
    logic [STALL_W-1:0] stall_cnt;

    logic active;
    logic beat;
    logic is_match;
    logic stall;
    logic timeout_hit;
    logic arm;

    // Counter increment that holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v)
            return v;
        else
            return v + CNT_W'(1);
    endfunction

    assign active   = (state == RUN) || (state == DRAIN);
    assign beat     = active && act_valid;
    assign is_match = ((act_data ^ exp_data) & MASK) == '0;
    assign stall    = active && !exp_empty && !act_valid;
    // Fires in the TIMEOUT-th consecutive stall cycle; a beat in that cycle
    // is not a stall, so it is checked and no timeout occurs.
    assign timeout_hit = stall && (stall_cnt == STALL_W'(TIMEOUT - 1));
    // start is honoured only when no run is in progress.
    assign arm = start && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = RUN;
            RUN: begin
                if (timeout_hit)
                    state_nxt = DONE;
                else if (finish)
                    state_nxt = DRAIN;
            end
            DRAIN: if (timeout_hit || exp_empty) state_nxt = DONE;
            DONE:  if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        exp_pop = beat && !exp_empty;
        busy    = active;
        done    = (state == DONE);
    end

    // Derived only from registered state so inputs cannot glitch it.
    assign pass = done && (err_cnt == '0) && !timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_cnt <= '0;
            err_cnt   <= '0;
            first_exp <= '0;
            first_act <= '0;
            stall_cnt <= '0;
            timeout   <= 1'b0;
        end else if (arm) begin
            match_cnt <= '0;
            err_cnt   <= '0;
            first_exp <= '0;
            first_act <= '0;
            stall_cnt <= '0;
            timeout   <= 1'b0;
        end else begin
            if (beat) begin
                if (!exp_empty && is_match) begin
                    match_cnt <= sat_inc(match_cnt);
                end else begin
                    err_cnt <= sat_inc(err_cnt);
                    // err_cnt never returns to zero within a run, so zero
                    // marks the first error since start.
                    if (err_cnt == '0) begin
                        first_exp <= exp_empty ? '0 : exp_data;
                        first_act <= act_data;
                    end
                end
            end

            if (timeout_hit) begin
                stall_cnt <= '0;
                timeout   <= 1'b1;
            end else if (stall) begin
                stall_cnt <= stall_cnt + STALL_W'(1);
            end else begin
                stall_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sb_checker.sv
// ----------------------------------------------------------------------------
// tb_sb_checker -- directed bench for sb_checker.
// Three instances share the stimulus: u_dut (full mask), u_msk (low byte
// masked off) and u_sat (2-bit counters); all use TIMEOUT 8. The expected
// FIFO is a queue in the bench, popped on u_dut's exp_pop.
// ----------------------------------------------------------------------------
module tb_sb_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        finish;
    logic        act_valid;
    logic [31:0] act_data;
    logic        exp_empty;
    logic [31:0] exp_data;

    logic        pop_d, busy_d, done_d, to_d, pass_d;
    logic [15:0] mc_d, ec_d;
    logic [31:0] fe_d, fa_d;

    logic        pop_m, busy_m, done_m, to_m, pass_m;
    logic [15:0] mc_m, ec_m;
    logic [31:0] fe_m, fa_m;

    logic        pop_s, busy_s, done_s, to_s, pass_s;
    logic [1:0]  mc_s, ec_s;
    logic [31:0] fe_s, fa_s;

    logic [31:0] q[$];
    logic [31:0] tmp;
    logic        pop_now;
    int          pop_cnt;
    int          n_chk  = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    sb_checker #(.WIDTH(32), .TIMEOUT(8), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .start(start), .finish(finish),
        .act_valid(act_valid), .act_data(act_data),
        .exp_empty(exp_empty), .exp_data(exp_data), .exp_pop(pop_d),
        .match_cnt(mc_d), .err_cnt(ec_d), .first_exp(fe_d), .first_act(fa_d),
        .busy(busy_d), .done(done_d), .timeout(to_d), .pass(pass_d));

    sb_checker #(.WIDTH(32), .MASK(32'hFFFF_FF00), .TIMEOUT(8), .CNT_W(16)) u_msk (
        .clk(clk), .rst(rst), .start(start), .finish(finish),
        .act_valid(act_valid), .act_data(act_data),
        .exp_empty(exp_empty), .exp_data(exp_data), .exp_pop(pop_m),
        .match_cnt(mc_m), .err_cnt(ec_m), .first_exp(fe_m), .first_act(fa_m),
        .busy(busy_m), .done(done_m), .timeout(to_m), .pass(pass_m));

    sb_checker #(.WIDTH(32), .TIMEOUT(8), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .start(start), .finish(finish),
        .act_valid(act_valid), .act_data(act_data),
        .exp_empty(exp_empty), .exp_data(exp_data), .exp_pop(pop_s),
        .match_cnt(mc_s), .err_cnt(ec_s), .first_exp(fe_s), .first_act(fa_s),
        .busy(busy_s), .done(done_s), .timeout(to_s), .pass(pass_s));

    task automatic refresh();
        exp_empty = (q.size() == 0);
        exp_data  = exp_empty ? 32'h0 : q[0];
    endtask

    // One clock: sample exp_pop before the edge, pop the model FIFO after it.
    task automatic cyc();
        #1;
        pop_now = pop_d;
        n_chk++;
        if ({pop_m, pop_s} !== {pop_now, pop_now}) begin
            n_fail++;
            $display("FAIL pop_agree: msk=%b sat=%b required %b", pop_m, pop_s, pop_now);
        end
        @(posedge clk);
        #1;
        if (pop_now && q.size() > 0) begin
            tmp = q.pop_front();
            pop_cnt++;
        end
        refresh();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic beat(input logic [31:0] d);
        act_valid = 1'b1;
        act_data  = d;
        cyc();
        act_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic do_finish();
        finish = 1'b1;
        cyc();
        finish = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        // used only for reporting formatting of a single comparison
        n_chk++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 0; finish = 0; act_valid = 1'b1; act_data = 32'h5;
        q = {32'h5}; refresh();
        @(posedge clk); #1;
        n_chk++; if (pop_d !== 1'b0) begin n_fail++; $display("FAIL rst_pop: got %b required 0", pop_d); end
        n_chk++; if (busy_d !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b required 0", busy_d); end
        n_chk++; if (done_d !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b required 0", done_d); end
        n_chk++; if (pass_d !== 1'b0) begin n_fail++; $display("FAIL rst_pass: got %b required 0", pass_d); end
        n_chk++; if (to_d !== 1'b0) begin n_fail++; $display("FAIL rst_timeout: got %b required 0", to_d); end
        n_chk++; if ({mc_d, ec_d} !== 32'h0) begin n_fail++; $display("FAIL rst_cnt: got %h/%h required 0/0", mc_d, ec_d); end
        n_chk++; if ({fe_d, fa_d} !== 64'h0) begin n_fail++; $display("FAIL rst_first: got %h/%h required 0/0", fe_d, fa_d); end
        act_valid = 1'b0;
        rst = 1'b0;
        q.delete(); refresh();
    endtask

    task automatic test_ignored_idle();
        pop_cnt = 0;
        q = {32'h55}; refresh();
        beat(32'h55);
        finish = 1'b1; cyc(); finish = 1'b0;
        n_chk++; if (pop_cnt !== 0) begin n_fail++; $display("FAIL idle_pop: got %0d pops required 0", pop_cnt); end
        n_chk++; if ({mc_d, ec_d} !== 32'h0) begin n_fail++; $display("FAIL idle_cnt: got %h/%h required 0/0", mc_d, ec_d); end
        n_chk++; if ({busy_d, done_d} !== 2'b00) begin n_fail++; $display("FAIL idle_state: got busy/done %b required 00", {busy_d, done_d}); end
        q.delete(); refresh();
    endtask

    task automatic test_clean();
        pop_cnt = 0;
        q = {32'h11, 32'h22, 32'h33}; refresh();
        do_start();
        n_chk++; if (busy_d !== 1'b1) begin n_fail++; $display("FAIL clean_busy: got %b required 1", busy_d); end
        beat(32'h11); beat(32'h22); beat(32'h33);
        do_finish();
        n_chk++; if (busy_d !== 1'b1) begin n_fail++; $display("FAIL clean_drain: got busy %b required 1", busy_d); end
        cyc();
        n_chk++; if (pop_cnt !== 3) begin n_fail++; $display("FAIL clean_pops: got %0d required 3", pop_cnt); end
        n_chk++; if (mc_d !== 16'd3) begin n_fail++; $display("FAIL clean_match: got %0d required 3", mc_d); end
        n_chk++; if (ec_d !== 16'd0) begin n_fail++; $display("FAIL clean_err: got %0d required 0", ec_d); end
        n_chk++; if ({done_d, pass_d, busy_d} !== 3'b110) begin n_fail++; $display("FAIL clean_done: got done/pass/busy %b required 110", {done_d, pass_d, busy_d}); end
    endtask

    task automatic test_mismatch();
        q = {32'hA5A5_A5A5, 32'h1}; refresh();
        do_start();
        n_chk++; if ({mc_d, ec_d} !== 32'h0) begin n_fail++; $display("FAIL restart_clear: got %h/%h required 0/0", mc_d, ec_d); end
        beat(32'hA5A5_A5A4);
        n_chk++; if (ec_d !== 16'd1) begin n_fail++; $display("FAIL mm_err: got %0d required 1", ec_d); end
        n_chk++; if (fe_d !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL mm_first_exp: got %h required a5a5a5a5", fe_d); end
        n_chk++; if (fa_d !== 32'hA5A5_A5A4) begin n_fail++; $display("FAIL mm_first_act: got %h required a5a5a5a4", fa_d); end
        beat(32'h2);
        n_chk++; if (ec_d !== 16'd2) begin n_fail++; $display("FAIL mm_err2: got %0d required 2", ec_d); end
        n_chk++; if ({fe_d, fa_d} !== {32'hA5A5_A5A5, 32'hA5A5_A5A4}) begin n_fail++; $display("FAIL mm_keep_first: got %h/%h required a5a5a5a5/a5a5a5a4", fe_d, fa_d); end
        n_chk++; if ({mc_m, ec_m} !== {16'd2, 16'd0}) begin n_fail++; $display("FAIL mm_masked: got %0d/%0d required 2/0", mc_m, ec_m); end
        do_finish(); cyc();
        n_chk++; if ({done_d, pass_d} !== 2'b10) begin n_fail++; $display("FAIL mm_pass: got done/pass %b required 10", {done_d, pass_d}); end
        n_chk++; if ({done_m, pass_m} !== 2'b11) begin n_fail++; $display("FAIL mm_msk_pass: got done/pass %b required 11", {done_m, pass_m}); end
    endtask

    task automatic test_mask();
        q = {32'h1234_5678}; refresh();
        do_start();
        beat(32'h1234_56FF);
        n_chk++; if ({mc_m, ec_m} !== {16'd1, 16'd0}) begin n_fail++; $display("FAIL mask_cnt: got %0d/%0d required 1/0", mc_m, ec_m); end
        n_chk++; if ({mc_d, ec_d} !== {16'd0, 16'd1}) begin n_fail++; $display("FAIL nomask_cnt: got %0d/%0d required 0/1", mc_d, ec_d); end
        n_chk++; if (fe_d !== 32'h1234_5678) begin n_fail++; $display("FAIL nomask_first: got %h required 12345678", fe_d); end
        do_finish(); cyc();
    endtask

    task automatic test_unexpected();
        pop_cnt = 0;
        q.delete(); refresh();
        do_start();
        act_valid = 1'b1; act_data = 32'hDEAD_0001;
        #1;
        n_chk++; if (pop_d !== 1'b0) begin n_fail++; $display("FAIL unexp_pop: got %b required 0", pop_d); end
        cyc(); act_valid = 1'b0;
        n_chk++; if (ec_d !== 16'd1) begin n_fail++; $display("FAIL unexp_err: got %0d required 1", ec_d); end
        n_chk++; if ({fe_d, fa_d} !== {32'h0, 32'hDEAD_0001}) begin n_fail++; $display("FAIL unexp_first: got %h/%h required 0/dead0001", fe_d, fa_d); end
        n_chk++; if (pop_cnt !== 0) begin n_fail++; $display("FAIL unexp_pops: got %0d required 0", pop_cnt); end
        do_finish(); cyc();
    endtask

    task automatic test_timeout();
        q = {32'h77}; refresh();
        do_start();
        idle(7);
        n_chk++; if ({busy_d, to_d} !== 2'b10) begin n_fail++; $display("FAIL to_early: got busy/timeout %b required 10", {busy_d, to_d}); end
        cyc();
        n_chk++; if ({to_d, done_d, pass_d} !== 3'b110) begin n_fail++; $display("FAIL to_hit: got timeout/done/pass %b required 110", {to_d, done_d, pass_d}); end
        q.delete(); refresh();
    endtask

    task automatic test_beat_at_threshold();
        q = {32'h77, 32'h88}; refresh();
        do_start();
        n_chk++; if (to_d !== 1'b0) begin n_fail++; $display("FAIL to_clear: got %b required 0", to_d); end
        idle(7);
        beat(32'h77);
        n_chk++; if ({busy_d, to_d, mc_d} !== {2'b10, 16'd1}) begin n_fail++; $display("FAIL thr_beat: got busy/timeout %b match %0d required 10 / 1", {busy_d, to_d}, mc_d); end
        idle(7);
        n_chk++; if ({busy_d, to_d} !== 2'b10) begin n_fail++; $display("FAIL thr_restall: got busy/timeout %b required 10", {busy_d, to_d}); end
        beat(32'h88);
        do_finish(); cyc();
        n_chk++; if ({done_d, pass_d, mc_d} !== {2'b11, 16'd2}) begin n_fail++; $display("FAIL thr_end: got done/pass %b match %0d required 11 / 2", {done_d, pass_d}, mc_d); end
    endtask

    task automatic test_finish_with_beat();
        q = {32'h99, 32'hAA}; refresh();
        do_start();
        beat(32'h99);
        do_start();
        n_chk++; if ({busy_d, mc_d} !== {1'b1, 16'd1}) begin n_fail++; $display("FAIL start_in_run: got busy %b match %0d required 1 / 1", busy_d, mc_d); end
        act_valid = 1'b1; act_data = 32'hAA; finish = 1'b1;
        cyc();
        act_valid = 1'b0; finish = 1'b0;
        n_chk++; if ({busy_d, mc_d} !== {1'b1, 16'd2}) begin n_fail++; $display("FAIL fin_beat: got busy %b match %0d required 1 / 2", busy_d, mc_d); end
        cyc();
        do_finish();
        n_chk++; if ({done_d, pass_d} !== 2'b11) begin n_fail++; $display("FAIL fin_done: got done/pass %b required 11", {done_d, pass_d}); end
    endtask

    task automatic test_reset_mid_run();
        q = {32'h1, 32'h2, 32'h3}; refresh();
        do_start();
        beat(32'h1); beat(32'h2);
        n_chk++; if (mc_d !== 16'd2) begin n_fail++; $display("FAIL mid_pre: got %0d required 2", mc_d); end
        rst = 1'b1; act_valid = 1'b1; act_data = 32'h3;
        #2;
        n_chk++; if ({mc_d, ec_d} !== 32'h0) begin n_fail++; $display("FAIL mid_cnt: got %h/%h required 0/0", mc_d, ec_d); end
        n_chk++; if ({busy_d, done_d, pop_d} !== 3'b000) begin n_fail++; $display("FAIL mid_async: got busy/done/pop %b required 000", {busy_d, done_d, pop_d}); end
        @(posedge clk); #1;
        rst = 1'b0;
        pop_cnt = 0;
        cyc();
        act_valid = 1'b0;
        n_chk++; if ({busy_d, mc_d, pop_cnt[0]} !== {1'b0, 16'd0, 1'b0}) begin n_fail++; $display("FAIL mid_idle: got busy %b match %0d pops %0d required 0/0/0", busy_d, mc_d, pop_cnt); end
        q.delete(); refresh();
    endtask

    task automatic test_saturation();
        q = {32'h1, 32'h2, 32'h3, 32'h4, 32'h5}; refresh();
        do_start();
        for (int i = 1; i <= 5; i++) beat(32'(i));
        chk("sat_match", {30'h0, mc_s}, 32'd3);
        chk("sat_err", {30'h0, ec_s}, 32'd0);
        chk("nosat_match", {16'h0, mc_d}, 32'd5);
        for (int i = 0; i < 5; i++) beat(32'hF0);
        chk("sat_err_hold", {30'h0, ec_s}, 32'd3);
        chk("sat_first", fa_s, 32'hF0);
        do_finish(); cyc();
        chk("sat_done", {31'h0, done_s & ~pass_s & ~to_s & ~busy_s}, 32'd1);
    endtask

    initial begin
        test_reset();
        test_ignored_idle();
        test_clean();
        test_mismatch();
        test_mask();
        test_unexpected();
        test_timeout();
        test_beat_at_threshold();
        test_finish_with_beat();
        test_reset_mid_run();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Hard stop in case a task ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sb_checker.md
SB_CHECKER -- requirements
Module: sb_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of compared words.
REQ-002 SHALL have parameter MASK, default {WIDTH{1'b1}}, bit mask applied before comparison.
REQ-003 SHALL have parameter TIMEOUT, default 1024, max stall cycles with expected data pending.
REQ-004 SHALL have parameter CNT_W, default 16, width of match/error counters.
REQ-005 SHALL have ports: clk input 1 clock; one clock domain, all logic on posedge clk.
REQ-006 SHALL have port rst input 1; reset is asynchronous and active-high.
REQ-007 SHALL have ports: start input 1, arm checker; finish input 1, stimulus done, begin drain.
REQ-008 SHALL have ports: act_valid input 1, DUT output word valid; act_data input WIDTH, DUT output word.
REQ-009 SHALL have ports: exp_empty input 1, expected FIFO empty; exp_data input WIDTH, expected FIFO head word.
REQ-010 SHALL have port exp_pop output 1, pop request to expected FIFO.
REQ-011 SHALL have ports: match_cnt output CNT_W; err_cnt output CNT_W; first_exp output WIDTH; first_act output WIDTH.
REQ-012 SHALL have ports: busy output 1; done output 1; timeout output 1; pass output 1.

Function
REQ-013 SHALL implement states IDLE, RUN, DRAIN, DONE; state SHALL be registered.
REQ-014 IDLE->RUN on start; RUN->DRAIN on finish; DRAIN->DONE when exp_empty; RUN or DRAIN->DONE on timeout; DONE->RUN on start, with counters and flags cleared on that edge.
REQ-015 start in RUN or DRAIN SHALL be ignored; finish outside RUN SHALL be ignored.
REQ-016 exp_pop SHALL be combinational: act_valid & !exp_empty & (state RUN or DRAIN); asserted for at most one cycle per act_valid beat.
REQ-017 On a popped beat, (act_data & MASK) == (exp_data & MASK) SHALL increment match_cnt, else increment err_cnt; update visible the cycle after the beat.
REQ-018 act_valid with exp_empty in RUN/DRAIN SHALL increment err_cnt (unexpected word), no pop.
REQ-019 act_valid in IDLE or DONE SHALL be ignored: no pop, no count change.
REQ-020 On the first error after start, first_exp and first_act SHALL capture exp_data (0 if exp_empty) and act_data; later errors SHALL NOT overwrite.
REQ-021 match_cnt and err_cnt SHALL saturate at 2^CNT_W-1, no wrap.
REQ-022 Stall counter SHALL increment each RUN/DRAIN cycle with !exp_empty & !act_valid, clear on any act_valid or exp_empty; reaching TIMEOUT SHALL set timeout and enter DONE the next cycle.
REQ-023 A beat and timeout threshold in the same cycle: the beat SHALL be checked and counted, stall counter cleared, no timeout.
REQ-024 busy SHALL be 1 in RUN and DRAIN; done SHALL be 1 in DONE only.
REQ-025 pass SHALL equal done & (err_cnt==0) & !timeout, registered-output-derived, no glitch from inputs.
REQ-026 finish and act_valid in the same RUN cycle: beat SHALL be checked, then state DRAIN.

Reset
REQ-027 rst high SHALL force, asynchronously: state IDLE, match_cnt 0, err_cnt 0, first_exp 0, first_act 0, stall counter 0, timeout 0.
REQ-028 During rst, exp_pop SHALL be 0, busy 0, done 0, pass 0.
REQ-029 rst asserted mid-RUN or mid-DRAIN SHALL abandon the run; after release checker SHALL stay IDLE until start.

Verification
REQ-030 Clean run: start; expected FIFO holds 0x11,0x22,0x33; three act_valid beats same values; finish -> 3 exp_pop pulses, match_cnt 3, err_cnt 0, done 1, pass 1.
REQ-031 Mismatch: expected 0xA5A5A5A5, actual 0xA5A5A5A4 -> err_cnt 1, first_exp 0xA5A5A5A5, first_act 0xA5A5A5A4, pass 0; a second mismatch leaves first_* unchanged.
REQ-032 Mask: MASK 0xFFFFFF00, expected 0x12345678, actual 0x123456FF -> match_cnt 1, err_cnt 0.
REQ-033 Timeout: TIMEOUT 8, one expected word pending, no act_valid for 8 cycles -> timeout 1, done 1, pass 0; a beat in the 8th stall cycle instead -> no timeout.
REQ-034 Unexpected/ignored: act_valid with exp_empty in RUN -> err_cnt 1, exp_pop 0; act_valid in IDLE -> no change.
REQ-035 Reset mid-run: rst pulse after 2 matches in RUN -> all counters 0, IDLE, busy 0; CNT_W 2 with 5 matches -> match_cnt 3.
